// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the ALU operation sequencer and the
// opcode decoder.
//   opcode_e   - operation select codes (12..15 are illegal)
//   state_e    - sequencer FSM states
//   alu_ctrl_t - ALU control word, field order matches the ALU port list
//   bsrc_e     - where the ALU b operand comes from
package alu_seq_pkg;

  localparam int W = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_NOT = 4'd5,
    OP_NEG = 4'd6,
    OP_INC = 4'd7,
    OP_DEC = 4'd8,
    OP_SHL = 4'd9,
    OP_ROR = 4'd10,
    OP_MUL = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic ci;
    logic nb;
    logic ic;
    logic na;
    logic xo;
    logic no;
    logic sr;
    logic ss;
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    B_OP    = 3'd0,  // registered op_b
    B_ZERO  = 3'd1,  // constant 0
    B_A     = 3'd2,  // registered op_a (doubling)
    B_SHAMT = 3'd3,  // op_b[3:0], rotate amount
    B_MULT  = 3'd4   // multiplicand or 0, selected by multiplier LSB
  } bsrc_e;

  // Last iteration index of the shift-and-add multiply.
  localparam logic [3:0] MUL_LAST = 4'd15;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode -> ALU control word decoder.
//   opcode  in  4   operation select
//   ctrl    out     ALU control word (all zero for illegal opcodes)
//   bsrc    out     b-operand source
//   ill     out 1   opcode is not a defined operation
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_ctrl_t  ctrl,
  output bsrc_e      bsrc,
  output logic       ill
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl = '0;
    bsrc = B_OP;
    ill  = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: ;
      OP_SUB: begin ctrl.ci = 1'b1; ctrl.nb = 1'b1; end
      OP_XOR: ctrl.ic = 1'b1;
      OP_OR:  begin ctrl.ic = 1'b1; ctrl.xo = 1'b1; end
      // AND via De Morgan: ~(~a | ~b), with the OR built from ic+xo.
      OP_AND: begin
        ctrl.ic = 1'b1; ctrl.na = 1'b1; ctrl.nb = 1'b1;
        ctrl.no = 1'b1; ctrl.xo = 1'b1;
      end
      OP_NOT: begin ctrl.nb = 1'b1; ctrl.ic = 1'b1; bsrc = B_ZERO; end
      OP_NEG: begin ctrl.ci = 1'b1; ctrl.na = 1'b1; bsrc = B_ZERO; end
      OP_INC: begin ctrl.ci = 1'b1; bsrc = B_ZERO; end
      OP_DEC: begin ctrl.nb = 1'b1; bsrc = B_ZERO; end
      OP_SHL: bsrc = B_A;
      OP_ROR: begin ctrl.sr = 1'b1; bsrc = B_SHAMT; end
      OP_MUL: bsrc = B_MULT;
      default: begin
        ill  = 1'b1;
        bsrc = B_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: opcode-driven initiator for the external 16-bit ALU.
//   clk, rst_n                  clock, async active-low reset
//   op_valid/op_ready           operation request handshake
//   opcode, op_a, op_b          operation and operands
//   alu_a, alu_b, alu_ci..ss    ALU operands and control word
//   alu_out, alu_cf, alu_zf     ALU result and flags
//   res_valid/res_ready         result handshake
//   result, res_cf, res_zf      captured result and flags
//   res_ill                     completed opcode was illegal
// Single-cycle ops spend one cycle in EXEC; MUL runs 16 shift-and-add
// iterations through the ALU's ADD path.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_ci,
  output logic         alu_nb,
  output logic         alu_ic,
  output logic         alu_na,
  output logic         alu_xo,
  output logic         alu_no,
  output logic         alu_sr,
  output logic         alu_ss,
  input  logic [W-1:0] alu_out,
  input  logic         alu_cf,
  input  logic         alu_zf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         res_cf,
  output logic         res_zf,
  output logic         res_ill
);

  state_e       state, state_nxt;
  logic [3:0]   opc;
  logic [W-1:0] ra, rb;
  logic [W-1:0] acc, m, q;
  logic         lost, ovf;
  logic [3:0]   cnt;
  logic         accept;
  logic         ovf_nxt;

  alu_ctrl_t    dec_ctrl;
  bsrc_e        dec_bsrc;
  logic         dec_ill;
  alu_ctrl_t    ctrl;

  assign op_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = op_valid && op_ready;

  // A multiplier bit that meets a multiplicand bit already shifted out
  // means the true product no longer fits in 16 bits.
  assign ovf_nxt = ovf | alu_cf | (q[0] & lost);

  alu_ctrl_decode u_decode (
    .opcode (opc),
    .ctrl   (dec_ctrl),
    .bsrc   (dec_bsrc),
    .ill    (dec_ill)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (opcode == OP_MUL) ? MUL : EXEC;
      EXEC:    state_nxt = DONE;
      MUL:     if (cnt == MUL_LAST) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive: only EXEC (legal opcode) and MUL put anything on the bus.
  always_comb begin
    ctrl  = '0;
    alu_a = '0;
    alu_b = '0;
    if (state == EXEC && !dec_ill) begin
      ctrl  = dec_ctrl;
      alu_a = ra;
      case (dec_bsrc)
        B_OP:    alu_b = rb;
        B_A:     alu_b = ra;
        B_SHAMT: alu_b = {12'b0, rb[3:0]};
        default: alu_b = '0;
      endcase
    end else if (state == MUL) begin
      alu_a = acc;
      alu_b = q[0] ? m : '0;
    end
  end

  assign {alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss} = ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc     <= '0;
      ra      <= '0;
      rb      <= '0;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      lost    <= 1'b0;
      ovf     <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      res_cf  <= 1'b0;
      res_zf  <= 1'b0;
      res_ill <= 1'b0;
    end else begin
      if (accept) begin
        opc  <= opcode;
        ra   <= op_a;
        rb   <= op_b;
        acc  <= '0;
        m    <= op_a;
        q    <= op_b;
        lost <= 1'b0;
        ovf  <= 1'b0;
        cnt  <= '0;
      end

      if (state == EXEC) begin
        result  <= dec_ill ? '0 : alu_out;
        res_cf  <= dec_ill ? 1'b0 : alu_cf;
        res_zf  <= dec_ill ? 1'b1 : alu_zf;
        res_ill <= dec_ill;
      end

      if (state == MUL) begin
        acc  <= alu_out;
        ovf  <= ovf_nxt;
        lost <= lost | m[W-1];
        m    <= m << 1;
        q    <= q >> 1;
        cnt  <= cnt + 4'd1;
        if (cnt == MUL_LAST) begin
          result  <= alu_out;
          res_cf  <= ovf_nxt;
          res_zf  <= (alu_out == '0);
          res_ill <= 1'b0;
        end
      end
    end
  end

endmodule
